// File: rtl/vote_auth_if.sv
// Ballot-unit bus between the button panel and the vote authorisation controller.
// The master drives buttons and the disable lamp; the slave returns vote/status pulses.
interface vote_auth_if #(
   parameter int N_CAND = 4
);
   localparam int IDX_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;

   logic [N_CAND-1:0] button;
   logic              red_led;
   logic              valid_vote;
   logic [IDX_W-1:0]  vote_idx;
   logic              multi_err;
   logic              busy;

   modport master (
      output button, red_led,
      input  valid_vote, vote_idx, multi_err, busy
   );

   modport slave (
      input  button, red_led,
      output valid_vote, vote_idx, multi_err, busy
   );
endinterface

// File: rtl/vote_auth_ctrl.sv
// Vote authorisation FSM: accepts a single long button press, rejects multi-presses,
// then waits for a clean all-released lockout interval before re-arming.
module vote_auth_ctrl #(
   parameter int N_CAND      = 4,
   parameter int HOLD_CYCLES = 50000,
   parameter int LOCK_CYCLES = 100000
) (
   input  logic        clock,
   input  logic        reset,
   vote_auth_if.slave  bus
);
   localparam int IDX_W   = (N_CAND > 1) ? $clog2(N_CAND) : 1;
   localparam int MAX_CYC = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // Decisions are taken on the edge whose increment would reach the target count.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_FULL = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HOLD     = 3'd1,
      REJECT   = 3'd2,
      WAIT_REL = 3'd3,
      LOCK     = 3'd4
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  vote_idx_q;
   logic              valid_q;
   logic              multi_q;
   logic              busy_q;

   logic [N_CAND-1:0] pressed;
   logic [N_CAND-1:0] others;
   logic              any_low;
   logic              multi_low;
   logic [IDX_W-1:0]  low_idx;

   always_comb begin
      pressed   = ~bus.button;
      any_low   = |pressed;
      // Clearing the lowest set bit leaves something only when two or more are pressed.
      multi_low = |(pressed & (pressed - N_CAND'(1)));
      others    = pressed & ~(N_CAND'(1) << idx_q);
      low_idx   = '0;
      for (int i = 0; i < N_CAND; i++) begin
         if (pressed[i]) low_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         vote_idx_q <= '0;
         valid_q    <= 1'b0;
         multi_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         multi_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (multi_low) begin
                  state_q <= REJECT;
                  multi_q <= 1'b1;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end else if (any_low) begin
                  state_q <= HOLD;
                  idx_q   <= low_idx;
                  cnt_q   <= CNT_ONE;
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q  <= '0;
                  busy_q <= 1'b0;
               end
            end
            HOLD: begin
               // A second button beats both release and acceptance on the same edge.
               if (|others) begin
                  state_q <= REJECT;
                  multi_q <= 1'b1;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end else if (!pressed[idx_q]) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q >= HOLD_LAST) begin
                  state_q <= WAIT_REL;
                  cnt_q   <= HOLD_FULL;
                  busy_q  <= 1'b1;
                  if (!bus.red_led) begin
                     valid_q    <= 1'b1;
                     vote_idx_q <= idx_q;
                  end
               end else begin
                  cnt_q  <= cnt_q + CNT_ONE;
                  busy_q <= 1'b1;
               end
            end
            REJECT, WAIT_REL: begin
               busy_q <= 1'b1;
               if (!any_low) begin
                  state_q <= LOCK;
                  cnt_q   <= '0;
               end
            end
            LOCK: begin
               // Any bounce restarts the quiet interval; presses here never start a hold.
               if (any_low) begin
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
               end else if (cnt_q >= LOCK_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q + CNT_ONE;
                  busy_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.valid_vote = valid_q;
   assign bus.vote_idx   = vote_idx_q;
   assign bus.multi_err  = multi_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_vote_auth_ctrl.sv
// Directed bench for vote_auth_ctrl with N_CAND=4, HOLD_CYCLES=8, LOCK_CYCLES=4.
module tb_vote_auth_ctrl;
   localparam int N_CAND      = 4;
   localparam int HOLD_CYCLES = 8;
   localparam int LOCK_CYCLES = 4;

   logic clock;
   logic reset;

   vote_auth_if #(.N_CAND(N_CAND)) bus ();

   vote_auth_ctrl #(
      .N_CAND      (N_CAND),
      .HOLD_CYCLES (HOLD_CYCLES),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int vcount = 0;
   int mcount = 0;
   bit both_seen = 1'b0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Pulse counters sampled mid-cycle.
   always @(negedge clock) begin
      if (bus.valid_vote === 1'b1) vcount++;
      if (bus.multi_err === 1'b1) mcount++;
      if (bus.valid_vote === 1'b1 && bus.multi_err === 1'b1) both_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Release all buttons: one edge into LOCK, then LOCK_CYCLES quiet edges back to IDLE.
   task automatic release_lock(input string tag);
      bus.button = 4'b1111;
      step(LOCK_CYCLES);
      chk({tag, "_lock_busy"}, 32'(bus.busy), 32'd1);
      step(1);
      chk({tag, "_lock_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      reset       = 1'b0;
      bus.button  = 4'b1111;
      bus.red_led = 1'b0;
      #12;
      chk("rst_valid", 32'(bus.valid_vote), 32'd0);
      chk("rst_idx",   32'(bus.vote_idx),   32'd0);
      chk("rst_multi", 32'(bus.multi_err),  32'd0);
      chk("rst_busy",  32'(bus.busy),       32'd0);
      reset = 1'b1;
      step(2);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Nominal vote on candidate 1.
      bus.button = 4'b1101;
      step(HOLD_CYCLES - 1);
      chk("nom_pre_valid", 32'(bus.valid_vote), 32'd0);
      chk("nom_pre_busy",  32'(bus.busy),       32'd1);
      step(1);
      chk("nom_valid", 32'(bus.valid_vote), 32'd1);
      chk("nom_idx",   32'(bus.vote_idx),   32'd1);
      step(1);
      chk("nom_pulse_end", 32'(bus.valid_vote), 32'd0);
      step(5);
      chk("nom_one_vote", 32'(vcount), 32'd1);
      release_lock("nom");

      // Short press of candidate 0.
      bus.button = 4'b1110;
      step(HOLD_CYCLES - 1);
      chk("short_busy", 32'(bus.busy), 32'd1);
      bus.button = 4'b1111;
      step(1);
      chk("short_idle",  32'(bus.busy),       32'd0);
      chk("short_valid", 32'(bus.valid_vote), 32'd0);
      step(2);
      chk("short_no_vote", 32'(vcount),       32'd1);
      chk("short_idx_kept", 32'(bus.vote_idx), 32'd1);

      // Two buttons straight from IDLE.
      bus.button = 4'b0110;
      step(1);
      chk("multi_a_err",   32'(bus.multi_err),  32'd1);
      chk("multi_a_valid", 32'(bus.valid_vote), 32'd0);
      chk("multi_a_busy",  32'(bus.busy),       32'd1);
      step(1);
      chk("multi_a_pulse_end", 32'(bus.multi_err), 32'd0);
      release_lock("multi_a");

      // Second button joins during HOLD.
      bus.button = 4'b1011;
      step(3);
      chk("multi_b_hold", 32'(bus.multi_err), 32'd0);
      bus.button = 4'b0011;
      step(1);
      chk("multi_b_err", 32'(bus.multi_err), 32'd1);
      step(HOLD_CYCLES);
      chk("multi_b_no_vote", 32'(vcount), 32'd1);
      chk("multi_b_count",   32'(mcount), 32'd2);
      release_lock("multi_b");

      // Disabled unit at acceptance; an earlier red_led blip must not matter.
      bus.button = 4'b1101;
      step(2);
      bus.red_led = 1'b1;
      step(1);
      bus.red_led = 1'b0;
      step(4);
      bus.red_led = 1'b1;
      step(1);
      chk("dis_valid", 32'(bus.valid_vote), 32'd0);
      chk("dis_busy",  32'(bus.busy),       32'd1);
      step(20);
      chk("dis_no_vote", 32'(vcount), 32'd1);
      bus.red_led = 1'b0;
      release_lock("dis");

      // Vote, then bounce during lockout.
      bus.button = 4'b1101;
      step(HOLD_CYCLES);
      chk("bnc_valid", 32'(bus.valid_vote), 32'd1);
      bus.button = 4'b1111;
      step(3);
      bus.button = 4'b0111;
      step(1);
      chk("bnc_busy",  32'(bus.busy),       32'd1);
      chk("bnc_multi", 32'(bus.multi_err),  32'd0);
      chk("bnc_valid_none", 32'(bus.valid_vote), 32'd0);
      bus.button = 4'b1111;
      step(LOCK_CYCLES - 1);
      chk("bnc_still_lock", 32'(bus.busy), 32'd1);
      step(1);
      chk("bnc_idle", 32'(bus.busy), 32'd0);
      chk("bnc_votes", 32'(vcount), 32'd2);

      // Asynchronous reset mid-HOLD, then continued hold counts as a new press.
      bus.button = 4'b1011;
      step(5);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_busy",  32'(bus.busy),       32'd0);
      chk("arst_valid", 32'(bus.valid_vote), 32'd0);
      chk("arst_idx",   32'(bus.vote_idx),   32'd0);
      #3;
      reset = 1'b1;
      step(HOLD_CYCLES - 1);
      chk("arst_pre_valid", 32'(bus.valid_vote), 32'd0);
      step(1);
      chk("arst_valid_after", 32'(bus.valid_vote), 32'd1);
      chk("arst_idx_after",   32'(bus.vote_idx),   32'd2);
      step(2);
      chk("arst_votes", 32'(vcount), 32'd3);
      release_lock("arst");

      chk("total_multi", 32'(mcount),    32'd2);
      chk("no_overlap",  32'(both_seen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vote_auth_ctrl.md
VOTE_AUTH_CTRL -- requirements
Module: vote_auth_ctrl

Interface
REQ-001 Parameter: N_CAND, default 4, number of candidate buttons, range 2..16.
REQ-002 Parameter: HOLD_CYCLES, default 50000, consecutive sampled-pressed edges required to accept a vote, minimum 2.
REQ-003 Parameter: LOCK_CYCLES, default 100000, consecutive all-released edges required before re-arming, minimum 1.
REQ-004 The design SHALL derive IDX_W = max(1, clog2(N_CAND)) and CNT_W = clog2(max(HOLD_CYCLES, LOCK_CYCLES) + 1).
REQ-005 Port: clock, input, 1, sole clock; all state changes on its rising edge.
REQ-006 Port: reset, input, 1, reset; asynchronous and active-low.
REQ-007 Port: button, input, N_CAND, active-low candidate buttons; bit i = 0 means candidate i is pressed.
REQ-008 Port: red_led, input, 1, ballot-unit disabled indicator; 1 blocks vote acceptance.
REQ-009 Port: valid_vote, output, 1, one-cycle pulse marking an accepted vote.
REQ-010 Port: vote_idx, output, IDX_W, index of the accepted candidate; meaningful while valid_vote = 1.
REQ-011 Port: multi_err, output, 1, one-cycle pulse on a multiple-press rejection.
REQ-012 Port: busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly five states: IDLE, HOLD, REJECT, WAIT_REL and LOCK.
REQ-014 IDLE, all buttons high: the block SHALL stay in IDLE with the counter at 0.
REQ-015 IDLE, exactly one button low: the block SHALL latch that index, load the counter with 1 and go to HOLD.
REQ-016 IDLE, two or more buttons low: the block SHALL go to REJECT and pulse multi_err for one cycle.
REQ-017 HOLD, latched button low and all others high: the counter SHALL increment by 1 per edge, saturating at HOLD_CYCLES.
REQ-018 HOLD, latched button released before the counter reaches HOLD_CYCLES: the block SHALL return to IDLE, clear the counter and emit no pulse.
REQ-019 HOLD, any other button low: the block SHALL go to REJECT and pulse multi_err; this takes priority over release and over acceptance on the same edge.
REQ-020 HOLD, counter == HOLD_CYCLES, latched button still low, red_led = 0 at that edge: valid_vote SHALL be 1 for exactly the following cycle, vote_idx SHALL equal the latched index, and the next state SHALL be WAIT_REL.
REQ-021 HOLD, counter == HOLD_CYCLES with red_led = 1: the block SHALL go to WAIT_REL with no valid_vote.
REQ-022 A held button SHALL never produce more than one valid_vote per press, regardless of hold length.
REQ-023 REJECT and WAIT_REL: the block SHALL remain until all buttons read high, then go to LOCK with the counter cleared.
REQ-024 LOCK: the counter SHALL increment on each all-released edge.
REQ-025 LOCK, any button low: the counter SHALL reset to 0 and the block SHALL stay in LOCK; it SHALL NOT go to HOLD or emit any pulse.
REQ-026 LOCK, counter reaching LOCK_CYCLES: the block SHALL go to IDLE.
REQ-027 vote_idx SHALL hold its last accepted value between votes; multi_err and valid_vote SHALL never be high in the same cycle.
REQ-028 red_led SHALL be sampled only at the acceptance edge; toggling it earlier in HOLD SHALL NOT affect the counter.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 On reset low, asynchronously: state = IDLE, counter = 0, latched index = 0, valid_vote = 0, vote_idx = 0, multi_err = 0, busy = 0.
REQ-031 Reset asserted mid-HOLD or mid-LOCK SHALL abort the operation with no pulse.
REQ-032 After reset deasserts, a button already held low SHALL be treated as a new press starting from IDLE.

Verification
REQ-033 All scenarios SHALL run with N_CAND = 4, HOLD_CYCLES = 8, LOCK_CYCLES = 4.
REQ-034 Scenario, nominal vote: button = 4'b1101 held 8 edges, red_led = 0 -> single valid_vote pulse with vote_idx = 1; release then 4 idle edges -> busy = 0.
REQ-035 Scenario, short press: button = 4'b1110 for 7 edges then released -> no valid_vote; FSM back in IDLE with busy = 0 the next cycle.
REQ-036 Scenario, multiple press: 4'b0110 from IDLE -> multi_err pulse, no vote. Separately, 4'b1011 held 3 edges then 4'b0011 -> multi_err pulse, no vote.
REQ-037 Scenario, disabled unit: red_led = 1 at the 8th edge of a valid hold -> no valid_vote, FSM enters WAIT_REL; held 20 more edges -> still no vote.
REQ-038 Scenario, lockout bounce: after a vote, release, press 4'b0111 at LOCK edge 2, release -> counter restarts, IDLE only after 4 clean edges, no vote from the bounce.
REQ-039 Scenario, async reset: reset driven low at HOLD edge 5 between clock edges -> outputs 0 immediately; hold continued 8 edges after release of reset -> one valid vote.
